pipeline_ctrl: RTL

Central stall/flush controller for the five-stage pipeline. Merges per-stage stall requests and the MEM-stage exception/ERET flush into per-register hold and bubble controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and drives the PC redirect. A small FSM defers an exception flush that arrives while MEM is stalled until the memory access completes.

---
 rtl/pipeline_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the five-stage pipeline.
// Optional perf counters enabled by defining PIPECTRL_PERF_CNT_EN.
module pipeline_ctrl #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall_req_if,
   input  logic                  stall_req_id,
   input  logic                  stall_req_ex,
   input  logic                  stall_req_mem,
   input  logic                  exc_flush,
   input  logic [ADDR_WIDTH-1:0] exc_pc,
   output logic [4:0]            stall,
   output logic [4:0]            flush,
   output logic                  redirect_valid,
   output logic [ADDR_WIDTH-1:0] redirect_pc,
`ifdef PIPECTRL_PERF_CNT_EN
   output logic [31:0]           perf_stall_cycles,
   output logic [31:0]           perf_flush_count,
`endif
   output logic                  pending
);

   typedef enum logic {
      IDLE,
      PEND
   } state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   pend_pc;

   logic                    src_if;
   logic                    src_id;
   logic                    src_ex;
   logic                    src_mem;
   logic [4:0]              norm_stall;
   logic [4:0]              norm_flush;
   logic                    take_now;
   logic                    take_pend;

   // One-hot of the latest requesting stage; later stages win.
   assign src_mem = stall_req_mem;
   assign src_ex  = stall_req_ex & ~stall_req_mem;
   assign src_id  = stall_req_id & ~stall_req_ex
                  & ~stall_req_mem;
   assign src_if  = stall_req_if & ~stall_req_id
                  & ~stall_req_ex & ~stall_req_mem;

   always_comb begin
      norm_stall = 5'b00000;
      norm_flush = 5'b00000;
      unique case (1'b1)
         src_mem: begin
            norm_stall = 5'b01111;
            norm_flush = 5'b10000;
         end
         src_ex: begin
            norm_stall = 5'b00111;
            norm_flush = 5'b01000;
         end
         src_id: begin
            norm_stall = 5'b00011;
            norm_flush = 5'b00100;
         end
         src_if: begin
            norm_stall = 5'b00001;
            norm_flush = 5'b00010;
         end
         default: begin
            norm_stall = 5'b00000;
            norm_flush = 5'b00000;
         end
      endcase
   end

   assign take_now  = (state == IDLE) & exc_flush
                    & ~stall_req_mem;
   assign take_pend = (state == PEND) & ~stall_req_mem;

   always_comb begin
      stall          = norm_stall;
      flush          = norm_flush;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      if (take_now || take_pend) begin
         stall          = 5'b00000;
         flush          = 5'b11111;
         redirect_valid = 1'b1;
         redirect_pc    = take_now ? exc_pc : pend_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pend_pc <= '0;
         pending <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (exc_flush && stall_req_mem) begin
                  state   <= PEND;
                  pend_pc <= exc_pc;
                  pending <= 1'b1;
               end
            end
            PEND: begin
               // Held instruction's own exception; new exc_pc ignored.
               if (!stall_req_mem) begin
                  state   <= IDLE;
                  pending <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               pending <= 1'b0;
            end
         endcase
      end
   end

`ifdef PIPECTRL_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (|stall)
            stall_cnt <= stall_cnt + 32'd1;
         if (redirect_valid)
            flush_cnt <= flush_cnt + 32'd1;
      end
   end

   assign perf_stall_cycles = stall_cnt;
   assign perf_flush_count  = flush_cnt;
`endif

endmodule
